// File: rtl/order_issuer.sv
// Order issuer: stages one action set per stock, issues up to three market orders under a
// per-stock/per-market position limit into a FWFT FIFO. Optional macro: ORDER_DEDUP_EN.
module order_issuer #(
    parameter int FIFO_DEPTH = 8,
    parameter int POS_LIMIT  = 7,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    stock_id,
    input  logic [1:0]    action_a,
    input  logic [1:0]    action_b,
    input  logic [1:0]    action_c,
    input  logic [15:0]   price_a,
    input  logic [15:0]   price_b,
    input  logic [15:0]   price_c,
    output logic          ord_valid,
    input  logic          ord_ready,
    output logic [1:0]    ord_market,
    output logic          ord_side,
    output logic [1:0]    ord_stock,
    output logic [15:0]   ord_price,
    output logic [AW:0]   fifo_count,
    output logic [7:0]    drop_count,
    output logic [1:0]    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and the FIFO head is held stable while valid && !ready.

    typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B, ISSUE_C} state_t;

    localparam logic [1:0]        ACT_HOLD = 2'b00;
    localparam logic [1:0]        ACT_BUY  = 2'b01;
    localparam logic [1:0]        ACT_SELL = 2'b10;
    localparam logic signed [7:0] LIM      = 8'(POS_LIMIT);
    localparam logic signed [7:0] NEG_LIM  = -LIM;
    localparam logic [AW:0]       DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    state_t             state_q, state_d;
    logic [1:0]         stg_stock_q, stg_stock_d;
    logic [1:0]         stg_act_q [3];
    logic [1:0]         stg_act_d [3];
    logic [15:0]        stg_price_q [3];
    logic [15:0]        stg_price_d [3];
    logic signed [7:0]  pos_q [4][3];
    logic signed [7:0]  pos_d [4][3];
    logic [7:0]         drop_q, drop_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [20:0]        mem_q [FIFO_DEPTH];
    logic [20:0]        mem_d [FIFO_DEPTH];
`ifdef ORDER_DEDUP_EN
    logic [1:0]         last_action_q [4][3];
    logic [1:0]         last_action_d [4][3];
`endif

    logic [1:0]         in_act [3];
    logic [15:0]        in_price [3];
    logic [1:0]         slot;
    logic [1:0]         cur_act;
    logic signed [7:0]  cur_pos;
    logic               is_buy, is_sell, allow, full, push, pop, drop;
    logic [20:0]        head;

    always_comb begin
        in_act[0]   = (action_a == 2'b11) ? ACT_HOLD : action_a;
        in_act[1]   = (action_b == 2'b11) ? ACT_HOLD : action_b;
        in_act[2]   = (action_c == 2'b11) ? ACT_HOLD : action_c;
        in_price[0] = price_a;
        in_price[1] = price_b;
        in_price[2] = price_c;
    end

    always_comb begin
        state_d     = state_q;
        stg_stock_d = stg_stock_q;
        stg_act_d   = stg_act_q;
        stg_price_d = stg_price_q;
        pos_d       = pos_q;
        drop_d      = drop_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
`ifdef ORDER_DEDUP_EN
        last_action_d = last_action_q;
`endif
        in_ready = (state_q == IDLE);

        case (state_q)
            ISSUE_B: slot = 2'd1;
            ISSUE_C: slot = 2'd2;
            default: slot = 2'd0;
        endcase
        cur_act = stg_act_q[slot];
        cur_pos = pos_q[stg_stock_q][slot];
        is_buy  = (state_q != IDLE) && (cur_act == ACT_BUY);
        is_sell = (state_q != IDLE) && (cur_act == ACT_SELL);
        allow   = (is_buy && (cur_pos < LIM)) || (is_sell && (cur_pos > NEG_LIM));
        // Fullness is judged on the pre-pop count, so a full FIFO blocks a push even when popping.
        full    = (count_q == DEPTH_C);
        push    = allow && !full;
        drop    = (is_buy || is_sell) && !allow;
        pop     = (count_q != '0) && ord_ready;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    stg_stock_d = stock_id;
                    for (int m = 0; m < 3; m++) begin
                        stg_price_d[m] = in_price[m];
`ifdef ORDER_DEDUP_EN
                        stg_act_d[m] = (in_act[m] == last_action_q[stock_id][m]) ? ACT_HOLD
                                                                                 : in_act[m];
                        last_action_d[stock_id][m] = in_act[m];
`else
                        stg_act_d[m] = in_act[m];
`endif
                    end
                    state_d = ISSUE_A;
                end
            end
            ISSUE_A: if (!(allow && full)) state_d = ISSUE_B;
            ISSUE_B: if (!(allow && full)) state_d = ISSUE_C;
            default: if (!(allow && full)) state_d = IDLE;
        endcase

        if (push) begin
            pos_d[stg_stock_q][slot] = is_buy ? (cur_pos + 8'sd1) : (cur_pos - 8'sd1);
            mem_d[wr_ptr_q] = {slot, is_buy, stg_stock_q, stg_price_q[slot]};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stg_stock_q <= '0;
            for (int m = 0; m < 3; m++) begin
                stg_act_q[m]   <= ACT_HOLD;
                stg_price_q[m] <= '0;
            end
            for (int s = 0; s < 4; s++) begin
                for (int m = 0; m < 3; m++) begin
                    pos_q[s][m] <= '0;
`ifdef ORDER_DEDUP_EN
                    last_action_q[s][m] <= ACT_HOLD;
`endif
                end
            end
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q     <= state_d;
            stg_stock_q <= stg_stock_d;
            stg_act_q   <= stg_act_d;
            stg_price_q <= stg_price_d;
            pos_q       <= pos_d;
`ifdef ORDER_DEDUP_EN
            last_action_q <= last_action_d;
`endif
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        ord_valid  = (count_q != '0);
        head       = ord_valid ? mem_q[rd_ptr_q] : 21'd0;
        ord_market = head[20:19];
        ord_side   = head[18];
        ord_stock  = head[17:16];
        ord_price  = head[15:0];
        fifo_count = count_q;
        drop_count = drop_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_order_issuer.sv
// Self-checking bench for order_issuer: randomized action sets against a queue-based order model.
module tb_order_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  stock_id = '0;
    logic [1:0]  action_a = '0, action_b = '0, action_c = '0;
    logic [15:0] price_a = '0, price_b = '0, price_c = '0;
    logic        ord_valid;
    logic        ord_ready = 1'b0;
    logic [1:0]  ord_market;
    logic        ord_side;
    logic [1:0]  ord_stock;
    logic [15:0] ord_price;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    // model: expected order stream {market, side, stock, price}, positions, drops
    logic [20:0] exp_q[$];
    int          pos_m [4][3];
    int          drops_m;
    logic [1:0]  last_m [4][3];

    localparam int LIMIT = 7;

    order_issuer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .stock_id(stock_id), .action_a(action_a), .action_b(action_b), .action_c(action_c),
        .price_a(price_a), .price_b(price_b), .price_c(price_c),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_market(ord_market),
        .ord_side(ord_side), .ord_stock(ord_stock), .ord_price(ord_price),
        .fifo_count(fifo_count), .drop_count(drop_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            if (rand_ready) ord_ready = 1'($urandom_range(0, 1));
        end
    end

    // head of the output must always be the oldest expected order
    always @(negedge clk) begin
        if (!reset && ord_valid) begin
            logic [20:0] got;
            got = {ord_market, ord_side, ord_stock, ord_price};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_order: got %h, expected no order", got);
            end else begin
                if (got !== exp_q[0]) begin
                    failures++;
                    $display("FAIL order_head: got %h, expected %h", got, exp_q[0]);
                end
                if (ord_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        drops_m = 0;
        for (int s = 0; s < 4; s++)
            for (int m = 0; m < 3; m++) begin
                pos_m[s][m] = 0;
                last_m[s][m] = 2'b00;
            end
    endtask

    task automatic model_accept(input logic [1:0] stk, input logic [1:0] acts [3],
                                input logic [15:0] prices [3]);
        for (int m = 0; m < 3; m++) begin
            logic [1:0] a;
            a = (acts[m] == 2'b11) ? 2'b00 : acts[m];
`ifdef ORDER_DEDUP_EN
            if (a == last_m[stk][m]) begin
                last_m[stk][m] = a;
                a = 2'b00;
            end else begin
                last_m[stk][m] = a;
            end
`endif
            if (a == 2'b01) begin
                if (pos_m[stk][m] < LIMIT) begin
                    exp_q.push_back({2'(m), 1'b1, stk, prices[m]});
                    pos_m[stk][m]++;
                end else if (drops_m < 255) drops_m++;
            end else if (a == 2'b10) begin
                if (pos_m[stk][m] > -LIMIT) begin
                    exp_q.push_back({2'(m), 1'b0, stk, prices[m]});
                    pos_m[stk][m]--;
                end else if (drops_m < 255) drops_m++;
            end
        end
    endtask

    task automatic do_reset();
        rand_ready = 1'b0;
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic send_set(input logic [1:0] stk, input logic [1:0] a, input logic [1:0] b,
                            input logic [1:0] c, input logic [15:0] pa, input logic [15:0] pb,
                            input logic [15:0] pc);
        logic [1:0]  acts [3];
        logic [15:0] prices [3];
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
            return;
        end
        stock_id = stk; action_a = a; action_b = b; action_c = c;
        price_a = pa; price_b = pb; price_c = pc;
        in_valid = 1'b1;
        acts[0] = a; acts[1] = b; acts[2] = c;
        prices[0] = pa; prices[1] = pb; prices[2] = pc;
        model_accept(stk, acts, prices);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        rand_ready = 1'b0;
        @(posedge clk);
        #2 ord_ready = 1'b1;
        while (!(exp_q.size() == 0 && fifo_count == 0 && in_ready) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || fifo_count != 0) begin
            failures++;
            $display("FAIL drain: fifo_count=%0d pending_expected=%0d, expected 0/0",
                     fifo_count, exp_q.size());
        end
        checks++;
        if (drop_count !== 8'(drops_m)) begin
            failures++;
            $display("FAIL drop_count: got %0d, expected %0d", drop_count, drops_m);
        end
    endtask

    task automatic test_reset();
        ord_ready = 1'b0;
        do_reset();
        checks++;
        if ({in_ready, ord_valid, fifo_count, drop_count, dbg_state} !== {1'b1, 1'b0, 4'd0, 8'd0, 2'd0}) begin
            failures++;
            $display("FAIL reset_state: in_ready=%0b ord_valid=%0b count=%0d drops=%0d state=%0d, expected 1 0 0 0 0",
                     in_ready, ord_valid, fifo_count, drop_count, dbg_state);
        end
        checks++;
        if ({ord_market, ord_side, ord_stock, ord_price} !== 21'd0) begin
            failures++;
            $display("FAIL reset_fields: got %h, expected 0", {ord_market, ord_side, ord_stock, ord_price});
        end
    endtask

    task automatic test_basic();
        ord_ready = 1'b1;
        send_set(2'd1, 2'b10, 2'b00, 2'b01, 16'd300, 16'd250, 16'd200);
        checks++;
        if ({ord_valid, in_ready, dbg_state} !== {1'b0, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL latency_t1: valid=%0b in_ready=%0b state=%0d, expected 0 0 1",
                     ord_valid, in_ready, dbg_state);
        end
        @(posedge clk); #1;
        checks++;
        if ({ord_valid, in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL latency_t2: valid=%0b in_ready=%0b, expected 1 0", ord_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL interval_t3: in_ready=%0b, expected 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL interval_t4: in_ready=%0b, expected 1", in_ready);
        end
        wait_drain(50);
    endtask

    task automatic test_pos_limit();
        do_reset();
        ord_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_set(2'd0, 2'b01, 2'b00, 2'b00, 16'(100 + i), 16'd0, 16'd0);
        wait_drain(100);
        checks++;
        if (drop_count !== 8'd1) begin
            failures++;
            $display("FAIL buy_limit_drops: got %0d, expected 1", drop_count);
        end
        for (int i = 0; i < 15; i++) send_set(2'd0, 2'b10, 2'b00, 2'b00, 16'(500 + i), 16'd0, 16'd0);
        wait_drain(100);
        checks++;
        if (drop_count !== 8'd2) begin
            failures++;
            $display("FAIL sell_limit_drops: got %0d, expected 2", drop_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ord_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_set(2'(i), 2'b01, 2'b01, 2'b01, 16'(10 * i + 1), 16'(10 * i + 2), 16'(10 * i + 3));
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({fifo_count, dbg_state, in_ready} !== {4'd8, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL full_stall: count=%0d state=%0d in_ready=%0b, expected 8 3 0",
                     fifo_count, dbg_state, in_ready);
        end
        ord_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({fifo_count, dbg_state} !== {4'd7, 2'd3}) begin
            failures++;
            $display("FAIL full_pop_no_push: count=%0d state=%0d, expected 7 3", fifo_count, dbg_state);
        end
        @(posedge clk); #1;
        checks++;
        if ({fifo_count, dbg_state} !== {4'd7, 2'd0}) begin
            failures++;
            $display("FAIL push_pop_same_cycle: count=%0d state=%0d, expected 7 0", fifo_count, dbg_state);
        end
        wait_drain(50);
    endtask

    task automatic test_mid_reset();
        do_reset();
        ord_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_set(2'd0, 2'b01, 2'b00, 2'b00, 16'(700 + i), 16'd0, 16'd0);
        wait_drain(100);
        ord_ready = 1'b0;
        send_set(2'd0, 2'b00, 2'b01, 2'b01, 16'd1, 16'd2, 16'd3);
        @(posedge clk); #1;
        checks++;
        if (dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL reach_issue_b: state=%0d, expected 2", dbg_state);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        checks++;
        if ({fifo_count, ord_valid, in_ready, drop_count} !== {4'd0, 1'b0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL mid_reset: count=%0d valid=%0b in_ready=%0b drops=%0d, expected 0 0 1 0",
                     fifo_count, ord_valid, in_ready, drop_count);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL no_push_after_reset: count=%0d, expected 0", fifo_count);
        end
        ord_ready = 1'b1;
        send_set(2'd0, 2'b01, 2'b00, 2'b00, 16'd4242, 16'd0, 16'd0);
        wait_drain(50);
    endtask

    task automatic test_random();
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++)
            send_set(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom));
        wait_drain(400);
    endtask

    task automatic test_drop_saturate();
        do_reset();
        ord_ready = 1'b1;
        for (int i = 0; i < 95; i++) send_set(2'd3, 2'b01, 2'b01, 2'b01, 16'(i), 16'(i + 1), 16'(i + 2));
        wait_drain(100);
        checks++;
        if (drop_count !== 8'd255) begin
            failures++;
            $display("FAIL drop_saturate: got %0d, expected 255", drop_count);
        end
    endtask

`ifdef ORDER_DEDUP_EN
    task automatic test_dedup();
        do_reset();
        ord_ready = 1'b1;
        send_set(2'd2, 2'b01, 2'b00, 2'b00, 16'd11, 16'd0, 16'd0);
        send_set(2'd2, 2'b01, 2'b00, 2'b00, 16'd12, 16'd0, 16'd0);
        send_set(2'd2, 2'b00, 2'b00, 2'b00, 16'd13, 16'd0, 16'd0);
        send_set(2'd2, 2'b01, 2'b00, 2'b00, 16'd14, 16'd0, 16'd0);
        wait_drain(50);
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_pos_limit();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_drop_saturate();
`ifdef ORDER_DEDUP_EN
        test_dedup();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/order_issuer.md
ORDER_ISSUER -- requirements
Module: order_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, order FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter POS_LIMIT, default 7, maximum absolute net position per stock per market (1..127).
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning action set from the trade stage is present.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an action set this cycle.
REQ-007 SHALL have port stock_id, input, 2, meaning the stock the actions refer to.
REQ-008 SHALL have ports action_a / action_b / action_c, input, 2 each, with encoding 00 HOLD, 01 BUY, 10 SELL, 11 treated as HOLD.
REQ-009 SHALL have ports price_a / price_b / price_c, input, 16 each, meaning the quote carried into the order.
REQ-010 SHALL have ports for order output:
  - ord_valid, output, 1.
  - ord_ready, input, 1.
  - ord_market, output, 2, with encoding 0 A, 1 B, 2 C.
  - ord_side, output, 1, with encoding 1 BUY, 0 SELL.
  - ord_stock, output, 2.
  - ord_price, output, 16.
REQ-011 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1, meaning FIFO occupancy.
REQ-012 SHALL have port drop_count, output, 8, meaning orders rejected by the position limit.

Function
REQ-013 SHALL have FSM states IDLE, ISSUE_A, ISSUE_B, ISSUE_C; in_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE, when in_valid&in_ready, SHALL capture stock_id, the three actions and the three prices into staging registers and go to ISSUE_A.
REQ-015 Each ISSUE_x state SHALL process exactly slot x; it SHALL advance A->B->C->IDLE unless stalled.
REQ-016 A slot whose action is HOLD SHALL consume its cycle without a push.
REQ-017 A BUY slot SHALL push when pos[stock][x] < POS_LIMIT, then increment pos; otherwise SHALL drop the order and increment drop_count.
REQ-018 A SELL slot SHALL push when pos[stock][x] > -POS_LIMIT, then decrement pos; otherwise SHALL drop the order and increment drop_count.
REQ-019 pos SHALL be a 12-entry array (4 stocks x 3 markets) of signed 8-bit values, updated only on push.
REQ-020 If a slot would push while the FIFO is full, the FSM SHALL hold in that state, with no pos or drop update, until space exists.
REQ-021 Push SHALL be permitted only when fifo_count < FIFO_DEPTH, evaluated before any same-cycle pop.
REQ-022 The FIFO SHALL be first-word-fall-through: ord_valid = (fifo_count != 0), and the head fields SHALL be valid with ord_valid.
REQ-023 Pop SHALL occur on ord_valid&ord_ready.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Output fields SHALL remain stable while ord_valid=1 and ord_ready=0.
REQ-026 Latency SHALL be as follows for acceptance at cycle T with slot A a BUY and the FIFO empty: push at T+1, ord_valid=1 at T+2.
REQ-027 The minimum acceptance interval SHALL be 4 cycles; in_ready SHALL be 0 during T+1..T+3.
REQ-028 drop_count SHALL saturate at 255.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE, with in_ready=1 on the following cycle.
REQ-030 On reset, the FIFO SHALL be emptied: ord_valid=0, fifo_count=0, and ord_market/ord_side/ord_stock/ord_price=0.
REQ-031 On reset, all pos entries SHALL be 0 and drop_count SHALL be 0.
REQ-032 Reset asserted mid-ISSUE SHALL discard the staged action set with no further push.

Configuration
REQ-033 With macro ORDER_DEDUP_EN defined, the block SHALL keep last_action[stock][market], reset to HOLD.
REQ-034 With ORDER_DEDUP_EN defined, a captured action equal to last_action for that stock/market SHALL be treated as HOLD.
REQ-035 With ORDER_DEDUP_EN defined, all three last_action entries SHALL update on capture.
REQ-036 Without ORDER_DEDUP_EN, every non-HOLD action SHALL be processed and no last_action storage SHALL exist.

Verification
REQ-037 Basic order: stock 1, A=SELL, B=HOLD, C=BUY, prices 300/250/200, ord_ready=1 -> two orders (A,SELL,1,300) then (C,BUY,1,200); pos[1][A]=-1, pos[1][C]=+1.
REQ-038 Position limit: eight consecutive BUY on stock 0 market A (dedup off) -> 7 orders, drop_count=1, pos[0][A]=7.
REQ-039 Backpressure: ord_ready=0, 3 action sets each with 3 orders, FIFO_DEPTH=8 -> fifo_count=8, FSM stalls in ISSUE_C, in_ready=0; then ord_ready=1 -> the 9th order enters, all 9 emerge in order.
REQ-040 Full-FIFO concurrency: fifo_count=8 with a push pending and a pop in the same cycle -> the push waits one cycle, no order lost.
REQ-041 Mid-operation reset: reset asserted in ISSUE_B -> next cycle fifo_count=0, ord_valid=0, in_ready=1, all pos=0.
REQ-042 Dedup on: same set A=BUY applied twice to stock 2 -> one order only; a third set with A=HOLD then A=BUY -> a second order.
